// File: rtl/led_gpio_pkg.sv
// Shared definitions for the LED/GPIO controller: channel mode encodings and field width.
package led_gpio_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_GPIO  = 2'b11
  } mode_e;

endpackage

// File: rtl/key_debounce.sv
// One push key: 2-flop synchroniser, then an optional stable-count debouncer (LED_GPIO_DEBOUNCE_EN).
// Output k is 1 while the key is pressed; everything clears to 0 (released) on reset.
module key_debounce #(
  parameter logic [15:0] DEB_CYC = 16'd10000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic k
);

  // Inverted on entry so the reset value of every stage means "not pressed".
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ~key_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef LED_GPIO_DEBOUNCE_EN
  logic        r_k;
  logic [15:0] r_cnt;

  // Any cycle where the synchronised key agrees with r_k restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k   <= 1'b0;
      r_cnt <= 16'd0;
    end else if (r_sync2 != r_k) begin
      if (DEB_CYC == 16'd0 || r_cnt >= DEB_CYC - 16'd1) begin
        r_k   <= r_sync2;
        r_cnt <= 16'd0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end else begin
      r_cnt <= 16'd0;
    end
  end

  assign k = r_k;
`else
  logic w_unused_deb;
  assign w_unused_deb = ^DEB_CYC;
  assign k            = r_sync2;
`endif

endmodule

// File: rtl/led_gpio_ctrl.sv
// LED channel controller (OFF/ON/BLINK/GPIO per channel) with a CPU GPIO register whose top bits carry key state.
// Key debouncing is enabled by defining LED_GPIO_DEBOUNCE_EN.
module led_gpio_ctrl
  import led_gpio_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          GPIO_W  = 16,
  parameter int          NUM_KEY = 2,
  parameter int          DIV_W   = 27,
  parameter logic [15:0] DEB_CYC = 16'd10000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_KEY-1:0]      key_n,
  input  logic [GPIO_W-1:0]       cpu_gpio_out,
  input  logic [GPIO_W-1:0]       cpu_gpio_en,
  output logic [GPIO_W-1:0]       cpu_gpio_in,
  input  logic [MODE_W*NUM_CH-1:0] cfg_mode,
  input  logic [DIV_W*NUM_CH-1:0] cfg_half,
  output logic [NUM_CH-1:0]       led
);

  logic [NUM_KEY-1:0] w_key;
  logic [GPIO_W-1:0]  w_gpio_nxt;
  logic [GPIO_W-1:0]  r_gpio_q;

  for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
    key_debounce #(
      .DEB_CYC (DEB_CYC)
    ) u_key (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_n[i]),
      .k     (w_key[i])
    );
  end

  // Key state owns the top NUM_KEY bits regardless of CPU enables.
  always_comb begin
    w_gpio_nxt = (r_gpio_q & ~cpu_gpio_en) | (cpu_gpio_out & cpu_gpio_en);
    w_gpio_nxt[GPIO_W-1 -: NUM_KEY] = w_key;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpio_q <= '0;
    end else begin
      r_gpio_q <= w_gpio_nxt;
    end
  end

  assign cpu_gpio_in = r_gpio_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mode_e            w_mode;
    logic [DIV_W-1:0] w_half;
    logic [DIV_W-1:0] r_cnt;
    logic             r_ph;
    logic             r_led;

    assign w_mode = mode_e'(cfg_mode[MODE_W*c +: MODE_W]);
    assign w_half = cfg_half[DIV_W*c +: DIV_W];

    // >= rather than == so shrinking the half-period mid-count toggles at once.
    always_ff @(posedge clk) begin
      if (rst || w_mode != MODE_BLINK) begin
        r_cnt <= '0;
        r_ph  <= 1'b0;
      end else if (r_cnt >= w_half) begin
        r_cnt <= '0;
        r_ph  <= ~r_ph;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_led <= 1'b0;
      end else begin
        case (w_mode)
          MODE_OFF:   r_led <= 1'b0;
          MODE_ON:    r_led <= 1'b1;
          MODE_BLINK: r_led <= r_ph;
          default:    r_led <= r_gpio_q[c];
        endcase
      end
    end

    assign led[c] = r_led;
  end

endmodule

// File: tb/tb_led_gpio_ctrl.sv
// Directed bench for led_gpio_ctrl: GPIO/mode vector table plus blink, reset and key sequences.
module tb_led_gpio_ctrl;

  localparam int NUM_CH  = 4;
  localparam int GPIO_W  = 16;
  localparam int NUM_KEY = 2;
  localparam int DIV_W   = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_KEY-1:0]        key_n;
  logic [GPIO_W-1:0]         cpu_gpio_out;
  logic [GPIO_W-1:0]         cpu_gpio_en;
  logic [GPIO_W-1:0]         cpu_gpio_in;
  logic [2*NUM_CH-1:0]       cfg_mode;
  logic [DIV_W*NUM_CH-1:0]   cfg_half;
  logic [NUM_CH-1:0]         led;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_gpio_ctrl #(
    .NUM_CH  (NUM_CH),
    .GPIO_W  (GPIO_W),
    .NUM_KEY (NUM_KEY),
    .DIV_W   (DIV_W),
    .DEB_CYC (16'd8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_n        (key_n),
    .cpu_gpio_out (cpu_gpio_out),
    .cpu_gpio_en  (cpu_gpio_en),
    .cpu_gpio_in  (cpu_gpio_in),
    .cfg_mode     (cfg_mode),
    .cfg_half     (cfg_half),
    .led          (led)
  );

  typedef struct {
    logic [15:0] out;
    logic [15:0] en;
    logic [7:0]  mode;
    logic [15:0] exp_in;
    logic [3:0]  exp_led;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Mode must be BLINK and phase/counter at 0 before the first step.
  task automatic blink_check(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s[%0d]", nm, i), {31'd0, led[0]}, (i / 4) % 2);
    end
  endtask

  // Steps until bit 15 of cpu_gpio_in equals val; returns edges taken (40 = gave up).
  task automatic wait_bit15(input logic val, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (cpu_gpio_in[15] !== val && cyc < 40);
  endtask

  initial begin
    int cyc;
    int hits;
    int lo;
    int hi;

    vecs[0] = '{16'hFFFF, 16'h0003, 8'h00, 16'h0003, 4'h0};
    vecs[1] = '{16'h0000, 16'h0001, 8'h00, 16'h0002, 4'h0};
    vecs[2] = '{16'hFFFF, 16'h0000, 8'h11, 16'h0002, 4'h5};
    vecs[3] = '{16'h00F0, 16'h00FF, 8'hFF, 16'h00F0, 4'h2};
    vecs[4] = '{16'h0005, 16'h000F, 8'hFF, 16'h00F5, 4'h0};
    vecs[5] = '{16'h0000, 16'h0000, 8'hFF, 16'h00F5, 4'h5};
    vecs[6] = '{16'hFFFF, 16'hC000, 8'h55, 16'h00F5, 4'hF};
    vecs[7] = '{16'h0000, 16'hFFFF, 8'h00, 16'h0000, 4'h0};

    rst          = 1'b1;
    key_n        = 2'b11;
    cpu_gpio_out = '0;
    cpu_gpio_en  = '0;
    cfg_mode     = '0;
    cfg_half     = '0;
    repeat (3) step();
    chk("reset_led", {28'd0, led}, 32'h0);
    chk("reset_gpio_in", {16'd0, cpu_gpio_in}, 32'h0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      cpu_gpio_out = vecs[v].out;
      cpu_gpio_en  = vecs[v].en;
      cfg_mode     = vecs[v].mode;
      step();
      chk($sformatf("vec%0d_gpio_in", v), {16'd0, cpu_gpio_in}, {16'd0, vecs[v].exp_in});
      chk($sformatf("vec%0d_led", v), {28'd0, led}, {28'd0, vecs[v].exp_led});
    end
    cpu_gpio_en = '0;

    // Blink, half-period 3: toggles every 4 cycles starting low.
    cfg_half[7:0] = 8'd3;
    cfg_mode      = 8'h02;
    blink_check("blink3", 16);

    // Half-period shrunk from 20 to 5 with the counter at 10.
    cfg_mode = 8'h00;
    step();
    cfg_half[7:0] = 8'd20;
    cfg_mode      = 8'h02;
    repeat (10) step();
    chk("shrink_pre", {31'd0, led[0]}, 32'd0);
    cfg_half[7:0] = 8'd5;
    for (int n = 0; n < 14; n++) begin
      step();
      chk($sformatf("shrink[%0d]", n), {31'd0, led[0]},
          (n == 0) ? 32'd0 : ((((n - 1) / 6) % 2 == 0) ? 32'd1 : 32'd0));
    end

    // Reset while the LED is high aborts the period.
    cfg_mode = 8'h00;
    step();
    cfg_half[7:0] = 8'd3;
    cfg_mode      = 8'h02;
    blink_check("pre_rst", 5);
    rst = 1'b1;
    step();
    chk("rst_led", {31'd0, led[0]}, 32'd0);
    chk("rst_gpio_in", {16'd0, cpu_gpio_in}, 32'h0);
    rst = 1'b0;
    blink_check("post_rst", 9);
    cfg_mode = 8'h00;

`ifdef LED_GPIO_DEBOUNCE_EN
    lo = 9;
    hi = 11;
    key_n = 2'b01;
    repeat (5) step();
    key_n = 2'b11;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cpu_gpio_in[15]) hits++;
    end
    chk("glitch_ignored", hits, 32'd0);
`else
    lo = 2;
    hi = 4;
`endif

    key_n = 2'b01;
    wait_bit15(1'b1, cyc);
    chk("press_latency_ok", {31'd0, (cyc >= lo && cyc <= hi)}, 32'd1);
    if (cyc < lo || cyc > hi) $display("FAIL press_latency: got %0d edges, want %0d..%0d", cyc, lo, hi);

    cpu_gpio_out = 16'h0000;
    cpu_gpio_en  = 16'h8000;
    step();
    chk("key_override", {16'd0, cpu_gpio_in}, 32'h8000);
    cpu_gpio_en = '0;

    key_n = 2'b11;
    wait_bit15(1'b0, cyc);
    chk("release_seen", {31'd0, cpu_gpio_in[15]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/led_gpio_ctrl.md
LED_GPIO_CTRL -- requirements
Module: led_gpio_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, number of LED channels (1..16).
REQ-002 Parameter GPIO_W, default 16, CPU GPIO width (must be at least NUM_CH and at least NUM_KEY).
REQ-003 Parameter NUM_KEY, default 2, number of active-low push keys.
REQ-004 Parameter DIV_W, default 27, blink half-period counter width.
REQ-005 Parameter DEB_CYC, default 16'd10000, debounce stable-cycle count.
REQ-006 Port clk, input, 1, single clock for all logic.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port key_n, input, NUM_KEY, asynchronous active-low keys.
REQ-009 Port cpu_gpio_out, input, GPIO_W, CPU GPIO output values.
REQ-010 Port cpu_gpio_en, input, GPIO_W, CPU GPIO output enables.
REQ-011 Port cpu_gpio_in, output, GPIO_W, registered GPIO state returned to the CPU.
REQ-012 Port cfg_mode, input, 2*NUM_CH, per-channel mode; channel c occupies bits [2c+1:2c].
REQ-013 Port cfg_half, input, DIV_W*NUM_CH, per-channel blink half-period in cycles minus 1.
REQ-014 Port led, output, NUM_CH, registered LED drive, active-high.

Function
REQ-015 Mode encodings SHALL be 00 OFF (led=0), 01 ON (led=1), 10 BLINK (led=phase), 11 GPIO (led=gpio_q[c]).
REQ-016 Each channel SHALL own a counter cnt[c] and a phase bit ph[c].
REQ-017 In BLINK, cnt SHALL increment each cycle; when cnt >= cfg_half[c], ph SHALL toggle and cnt SHALL return to 0.
REQ-018 Blink full period SHALL be 2*(cfg_half+1) cycles; cfg_half=0 toggles ph every cycle.
REQ-019 Lowering cfg_half below the current cnt SHALL cause a toggle on the next cycle; this uses the >= compare with no wrap.
REQ-020 In any mode other than BLINK, cnt and ph SHALL be held at 0, so entering BLINK starts with led=0 and the first toggle occurs after cfg_half+1 cycles.
REQ-021 The led output SHALL be registered, with a 1-cycle latency from a mode or phase change to the pin.
REQ-022 The GPIO register SHALL be updated every cycle as gpio_q <= (gpio_q & ~cpu_gpio_en) | (cpu_gpio_out & cpu_gpio_en).
REQ-023 Bits GPIO_W-NUM_KEY..GPIO_W-1 of gpio_q SHALL carry the debounced key-pressed state k (1 = pressed). These key bits SHALL override the CPU write in the same cycle.
REQ-024 cpu_gpio_in SHALL equal gpio_q.
REQ-025 GPIO mode on channel c SHALL reflect gpio_q[c] with 1 further cycle of latency.
REQ-026 Keys SHALL pass through a 2-flop synchroniser before any further use.

Reset
REQ-027 While rst=1 at a clk edge, all of the following SHALL clear to 0: gpio_q, cnt, ph, led, cpu_gpio_in, the debounced states, the debounce counters, and the synchronisers.
REQ-028 Reset asserted mid-blink SHALL abort the period, and channels SHALL restart per REQ-020 after release.
REQ-029 Keys held during reset SHALL be reported only after debounce completes following release of rst.

Configuration
REQ-030 Macro LED_GPIO_DEBOUNCE_EN defined: the debounced state k SHALL update only after the synchronised key differs from k for DEB_CYC consecutive cycles, and any bounce SHALL restart the count.
REQ-031 Macro LED_GPIO_DEBOUNCE_EN undefined: k SHALL equal the inverted synchroniser output (2-cycle latency), and no counter logic SHALL be generated.

Structure
REQ-032 Package led_gpio_pkg SHALL hold the mode constants (MODE_OFF, MODE_ON, MODE_BLINK, MODE_GPIO) and the mode field width of 2.
REQ-033 Sub-module key_debounce SHALL contain one synchroniser and one debouncer, with one instance per key; the macro of REQ-030/REQ-031 is applied inside it.
REQ-034 Per-channel blink logic SHALL be a generate loop within led_gpio_ctrl.

Verification
REQ-035 Blink: NUM_CH=4, ch0 BLINK, cfg_half=3 -> led[0] toggles every 4 cycles, 0 first, period 8.
REQ-036 Period change: cnt=10 and cfg_half changed 20->5 -> toggle on the next cycle, then every 6 cycles.
REQ-037 GPIO merge: en=0x0003, out=0xFFFF, starting from gpio_q=0 -> cpu_gpio_in=0x0003 after 1 cycle. Then en=0x0001, out=0 -> 0x0002.
REQ-038 Key override: CPU writes bit 15 = 0 while key_n[1]=0 and debounced -> bit 15 reads 1.
REQ-039 Debounce (macro on, DEB_CYC=8): 5-cycle glitch -> no change. Steady press -> bit set 2+8 cycles after the edge, within ±1 cycle.
REQ-040 Reset: rst pulse during ch0 BLINK with led=1 -> led=0 on the next cycle. After release, the first toggle occurs after cfg_half+1 cycles.
